sample_gain: RTL and testbench

SAMPLE_GAIN -- requirements
Module: sample_gain

---
 rtl/sample_gain_pkg.sv | 23 ++
 rtl/sample_gain_sat_scale.sv | 44 ++++
 rtl/sample_gain.sv | 140 ++++++++++++++
 tb/tb_sample_gain.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sample_gain_pkg.sv
// sample_gain_pkg
//   Shared definitions for the sample_gain block: FSM state encoding, datapath
//   widths and the bit positions of the fields inside the eq_vals control word.
package sample_gain_pkg;

  localparam int SAMPLE_W = 24;  // signed audio sample width
  localparam int GAIN_W   = 8;   // unsigned gain width (Q2.6 by default)

  // eq_vals field positions
  localparam int EQ_RGAIN_LSB  = 0;
  localparam int EQ_LGAIN_LSB  = 8;
  localparam int EQ_MUTE_BIT   = 16;
  localparam int EQ_BYPASS_BIT = 17;
  localparam int EQ_CAP_W      = 18;  // bits [17:0] are captured, the rest ignored

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MUL_L = 2'd1,
    MUL_R = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/sample_gain_sat_scale.sv
// sat_scale
//   Combinational gain stage: signed sample times zero-extended unsigned gain,
//   arithmetic right shift by GAIN_FRAC (floor), then saturation to the sample
//   width.
//   Ports:
//     sample  in  SAMPLE_W  signed input sample
//     gain    in  GAIN_W    unsigned gain, GAIN_FRAC fractional bits
//     result  out SAMPLE_W  signed, saturated scaled sample
module sat_scale
  import sample_gain_pkg::*;
#(
  parameter int GAIN_FRAC = 6
) (
  input  logic [SAMPLE_W-1:0] sample,
  input  logic [GAIN_W-1:0]   gain,
  output logic [SAMPLE_W-1:0] result
);

  localparam int PROD_W = SAMPLE_W + GAIN_W + 1;
  localparam int TOP_W  = PROD_W - SAMPLE_W + 1;

  logic signed [PROD_W-1:0] product;
  logic signed [PROD_W-1:0] shifted;
  logic        [TOP_W-1:0]  top_bits;

  // The extra zero bit keeps the gain non-negative inside a signed multiply.
  assign product  = $signed(sample) * $signed({1'b0, gain});
  assign shifted  = product >>> GAIN_FRAC;
  // The value fits in SAMPLE_W bits only if every bit from the sample sign bit
  // upward is a copy of the product sign.
  assign top_bits = shifted[PROD_W-1:SAMPLE_W-1];

  always_comb begin
    result = shifted[SAMPLE_W-1:0];
    if (!((&top_bits) || (~|top_bits))) begin
      if (shifted[PROD_W-1]) begin
        result = {1'b1, {(SAMPLE_W-1){1'b0}}};
      end else begin
        result = {1'b0, {(SAMPLE_W-1){1'b1}}};
      end
    end
  end

endmodule

// File: rtl/sample_gain.sv
// sample_gain
//   Stereo gain stage with mute and bypass. A sample pair is captured on
//   newsample and scaled through one shared multiplier, left then right; both
//   outputs update together and out_valid pulses three clocks after capture.
//   Ports:
//     clk        in   1   system clock
//     nreset     in   1   asynchronous active-low reset
//     left_in    in   24  signed left sample
//     right_in   in   24  signed right sample
//     newsample  in   1   one-clock pulse, inputs valid
//     eq_vals    in   32  [7:0] right gain, [15:8] left gain, [16] mute, [17] bypass
//     left_out   out  24  scaled left sample
//     right_out  out  24  scaled right sample
//     out_valid  out  1   one-clock pulse, outputs updated
//     busy       out  1   a pair is in process
//     overrun    out  1   sticky: newsample seen while busy
module sample_gain
  import sample_gain_pkg::*;
#(
  parameter int GAIN_FRAC = 6
) (
  input  logic                clk,
  input  logic                nreset,
  input  logic [SAMPLE_W-1:0] left_in,
  input  logic [SAMPLE_W-1:0] right_in,
  input  logic                newsample,
  input  logic [31:0]         eq_vals,
  output logic [SAMPLE_W-1:0] left_out,
  output logic [SAMPLE_W-1:0] right_out,
  output logic                out_valid,
  output logic                busy,
  output logic                overrun
);

  state_e              state_q, state_d;
  logic [SAMPLE_W-1:0] left_s_q, left_s_d;
  logic [SAMPLE_W-1:0] right_s_q, right_s_d;
  logic [EQ_CAP_W-1:0] eq_q, eq_d;
  logic [SAMPLE_W-1:0] left_res_q, left_res_d;
  logic [SAMPLE_W-1:0] left_out_q, left_out_d;
  logic [SAMPLE_W-1:0] right_out_q, right_out_d;
  logic                overrun_q, overrun_d;

  logic [SAMPLE_W-1:0] mul_sample;
  logic [GAIN_W-1:0]   mul_gain;
  logic [SAMPLE_W-1:0] scaled;
  logic [SAMPLE_W-1:0] chan_result;
  logic                unused_eq_bits;

  assign unused_eq_bits = ^eq_vals[31:EQ_CAP_W];

  // Shared multiplier operand select: right channel only in MUL_R.
  assign mul_sample = (state_q == MUL_R) ? right_s_q : left_s_q;
  assign mul_gain   = (state_q == MUL_R) ? eq_q[EQ_RGAIN_LSB +: GAIN_W]
                                         : eq_q[EQ_LGAIN_LSB +: GAIN_W];

  sat_scale #(
    .GAIN_FRAC (GAIN_FRAC)
  ) u_sat_scale (
    .sample (mul_sample),
    .gain   (mul_gain),
    .result (scaled)
  );

  // Mute has priority over bypass.
  always_comb begin
    chan_result = scaled;
    if (eq_q[EQ_MUTE_BIT]) begin
      chan_result = '0;
    end else if (eq_q[EQ_BYPASS_BIT]) begin
      chan_result = mul_sample;
    end
  end

  always_comb begin
    state_d     = state_q;
    left_s_d    = left_s_q;
    right_s_d   = right_s_q;
    eq_d        = eq_q;
    left_res_d  = left_res_q;
    left_out_d  = left_out_q;
    right_out_d = right_out_q;
    overrun_d   = overrun_q | (newsample && (state_q != IDLE));
    case (state_q)
      IDLE: begin
        if (newsample) begin
          left_s_d  = left_in;
          right_s_d = right_in;
          eq_d      = eq_vals[EQ_CAP_W-1:0];
          state_d   = MUL_L;
        end
      end
      MUL_L: begin
        left_res_d = chan_result;
        state_d    = MUL_R;
      end
      MUL_R: begin
        // Left result was parked a cycle earlier so both outputs move together.
        left_out_d  = left_res_q;
        right_out_d = chan_result;
        state_d     = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q     <= IDLE;
      left_s_q    <= '0;
      right_s_q   <= '0;
      eq_q        <= '0;
      left_res_q  <= '0;
      left_out_q  <= '0;
      right_out_q <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      left_s_q    <= left_s_d;
      right_s_q   <= right_s_d;
      eq_q        <= eq_d;
      left_res_q  <= left_res_d;
      left_out_q  <= left_out_d;
      right_out_q <= right_out_d;
      overrun_q   <= overrun_d;
    end
  end

  assign left_out  = left_out_q;
  assign right_out = right_out_q;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_sample_gain.sv
module tb_sample_gain;

  localparam int GF = 6;

  logic        clk;
  logic        nreset;
  logic [23:0] left_in;
  logic [23:0] right_in;
  logic        newsample;
  logic [31:0] eq_vals;
  logic [23:0] left_out;
  logic [23:0] right_out;
  logic        out_valid;
  logic        busy;
  logic        overrun;

  int checks = 0;
  int errors = 0;

  sample_gain #(.GAIN_FRAC(GF)) dut (
    .clk       (clk),
    .nreset    (nreset),
    .left_in   (left_in),
    .right_in  (right_in),
    .newsample (newsample),
    .eq_vals   (eq_vals),
    .left_out  (left_out),
    .right_out (right_out),
    .out_valid (out_valid),
    .busy      (busy),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  // Reference: value * gain / 2^GF rounded toward minus infinity, clamped to 24-bit signed.
  function automatic logic [23:0] ref_scale(input logic [23:0] s, input logic [7:0] g);
    longint p, q;
    p = longint'($signed(s)) * longint'(g);
    q = p / (64'sd1 <<< GF);
    if (p < 0 && (p % (64'sd1 <<< GF)) != 0) q = q - 1;
    if (q > 64'sd8388607) q = 64'sd8388607;
    if (q < -64'sd8388608) q = -64'sd8388608;
    return q[23:0];
  endfunction

  task automatic ref_pair(input logic [23:0] l, input logic [23:0] r, input logic [31:0] eq,
                          output logic [23:0] el, output logic [23:0] er);
    if (eq[16]) begin
      el = 24'd0; er = 24'd0;
    end else if (eq[17]) begin
      el = l; er = r;
    end else begin
      el = ref_scale(l, eq[15:8]);
      er = ref_scale(r, eq[7:0]);
    end
  endtask

  function automatic logic [31:0] mk_eq(input bit byp, input bit mute, input logic [7:0] lg, input logic [7:0] rg);
    return {14'h0, byp, mute, lg, rg};
  endfunction

  // Drive one pair, scramble inputs after capture, and check latency and results.
  task automatic do_pair(input string tag, input logic [23:0] l, input logic [23:0] r, input logic [31:0] eq);
    logic [23:0] el, er;
    int cnt;
    bit seen;
    ref_pair(l, r, eq, el, er);
    @(negedge clk);
    left_in = l; right_in = r; eq_vals = eq; newsample = 1'b1;
    @(posedge clk);
    #1;
    newsample = 1'b0;
    left_in = 24'($urandom); right_in = 24'($urandom); eq_vals = $urandom;
    cnt = 0; seen = 0;
    while (!seen && cnt < 8) begin
      @(negedge clk);
      cnt++;
      if (cnt == 1) check({tag, " busy"}, {31'd0, busy}, 32'd1);
      if (out_valid === 1'b1) seen = 1;
    end
    check({tag, " latency"}, cnt, 32'd3);
    check({tag, " left"}, {8'd0, left_out}, {8'd0, el});
    check({tag, " right"}, {8'd0, right_out}, {8'd0, er});
    @(negedge clk);
    check({tag, " valid_drop"}, {31'd0, out_valid}, 32'd0);
    check({tag, " left_hold"}, {8'd0, left_out}, {8'd0, el});
    $display("pair %s l=%h r=%h eq=%h -> %h %h", tag, l, r, eq[17:0], left_out, right_out);
  endtask

  task automatic do_reset();
    @(negedge clk);
    nreset = 1'b0;
    #1;
    check("rst overrun", {31'd0, overrun}, 32'd0);
    check("rst busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    nreset = 1'b1;
  endtask

  initial begin
    logic [23:0] l, r, el, er, al, ar;
    logic [31:0] eq;
    int vcount;

    nreset = 1'b0; newsample = 1'b0; left_in = '0; right_in = '0; eq_vals = '0;
    #2;
    check("reset left_out", {8'd0, left_out}, 32'd0);
    check("reset right_out", {8'd0, right_out}, 32'd0);
    check("reset out_valid", {31'd0, out_valid}, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset overrun", {31'd0, overrun}, 32'd0);
    repeat (2) @(negedge clk);
    nreset = 1'b1;

    // Directed corners
    do_pair("unity", 24'h100000, 24'hF00000, mk_eq(0, 0, 8'd64, 8'd64));
    check("unity left const", {8'd0, left_out}, 32'h100000);
    check("unity right const", {8'd0, right_out}, 32'hF00000);
    do_pair("floor_pos", 24'h000003, 24'h000003, mk_eq(0, 0, 8'd96, 8'd96));
    check("floor_pos const", {8'd0, left_out}, 32'h000004);
    do_pair("floor_neg", 24'hFFFFFD, 24'hFFFFFD, mk_eq(0, 0, 8'd96, 8'd96));
    check("floor_neg const", {8'd0, left_out}, 32'hFFFFFB);
    do_pair("saturate", 24'h400000, 24'hC00000, mk_eq(0, 0, 8'd255, 8'd255));
    check("sat left const", {8'd0, left_out}, 32'h7FFFFF);
    check("sat right const", {8'd0, right_out}, 32'h800000);
    do_pair("mute_byp", 24'h123456, 24'h876543, mk_eq(1, 1, 8'd64, 8'd64));
    check("mute const", {8'd0, left_out}, 32'h0);
    do_pair("bypass", 24'h123456, 24'h876543, mk_eq(1, 0, 8'd0, 8'd0));
    check("bypass const", {8'd0, right_out}, 32'h876543);
    do_pair("zero_gain", 24'h7FFFFF, 24'h800000, mk_eq(0, 0, 8'd0, 8'd0));

    // Randomized pairs against the reference
    for (int i = 0; i < 30; i++) begin
      l = 24'($urandom); r = 24'($urandom);
      eq = mk_eq(($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0),
                 8'($urandom), 8'($urandom));
      do_pair($sformatf("rand%0d", i), l, r, eq);
    end
    check("no overrun yet", {31'd0, overrun}, 32'd0);

    // Overrun: second newsample one clock after the first is dropped
    l = 24'h0ABCDE; r = 24'hF12345; eq = mk_eq(0, 0, 8'd80, 8'd32);
    ref_pair(l, r, eq, el, er);
    @(negedge clk);
    left_in = l; right_in = r; eq_vals = eq; newsample = 1'b1;
    @(posedge clk); #1;
    newsample = 1'b0;
    left_in = 24'h555555; right_in = 24'h222222; eq_vals = mk_eq(0, 0, 8'd1, 8'd1);
    @(negedge clk);
    newsample = 1'b1;
    @(posedge clk); #1;
    newsample = 1'b0;
    vcount = 0; al = '0; ar = '0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        vcount++;
        al = left_out; ar = right_out;
      end
    end
    check("ovr valid count", vcount, 32'd1);
    check("ovr left", {8'd0, al}, {8'd0, el});
    check("ovr right", {8'd0, ar}, {8'd0, er});
    check("ovr flag", {31'd0, overrun}, 32'd1);
    $display("overrun pulses=%0d l=%h r=%h overrun=%b", vcount, al, ar, overrun);
    do_pair("after_ovr", 24'h001000, 24'h002000, mk_eq(0, 0, 8'd64, 8'd128));
    check("ovr sticky", {31'd0, overrun}, 32'd1);
    do_reset();
    check("ovr cleared", {31'd0, overrun}, 32'd0);

    // newsample landing in DONE is dropped and flags overrun
    @(negedge clk);
    left_in = 24'h000100; right_in = 24'h000200; eq_vals = mk_eq(0, 0, 8'd64, 8'd64); newsample = 1'b1;
    @(posedge clk); #1;
    newsample = 1'b0;
    vcount = 0;
    while (out_valid !== 1'b1 && vcount < 8) begin
      @(negedge clk);
      vcount++;
    end
    check("done_ns reach", {31'd0, out_valid}, 32'd1);
    left_in = 24'h777777; newsample = 1'b1;
    @(posedge clk); #1;
    newsample = 1'b0;
    vcount = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (out_valid === 1'b1) vcount++;
    end
    check("done_ns dropped", vcount, 32'd0);
    check("done_ns overrun", {31'd0, overrun}, 32'd1);
    check("done_ns out", {8'd0, left_out}, 32'h000100);
    $display("done-newsample overrun=%b left=%h", overrun, left_out);

    // Reset abort in MUL_R
    do_reset();
    @(negedge clk);
    left_in = 24'h111111; right_in = 24'h222222; eq_vals = mk_eq(0, 0, 8'd64, 8'd64); newsample = 1'b1;
    @(posedge clk); #1;
    newsample = 1'b0;
    @(posedge clk); #2;
    check("abort in MUL_R busy", {31'd0, busy}, 32'd1);
    nreset = 1'b0;
    #1;
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort valid", {31'd0, out_valid}, 32'd0);
    check("abort left", {8'd0, left_out}, 32'd0);
    check("abort right", {8'd0, right_out}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    nreset = 1'b1;
    vcount = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (out_valid === 1'b1) vcount++;
    end
    check("abort no valid", vcount, 32'd0);
    $display("reset abort busy=%b out_valid=%b", busy, out_valid);
    do_pair("post_reset", 24'h0FFFFF, 24'hF00001, mk_eq(0, 0, 8'd32, 8'd128));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
